// File: rtl/if_id_skid.sv
// IF/ID pipeline register with valid/ready handshake, flush and NOP-bubble zeroing.
// Define IF_ID_SKID_EN to add a second (skid) entry so that if_ready depends on registers only.
module if_id_skid #(
  parameter int unsigned INST_W = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [INST_W-1:0] if_inst,
  input  logic [ADDR_W-1:0] if_cur_instaddress,
  input  logic [ADDR_W-1:0] if_next_instaddress,
  input  logic              if_excp,
  input  logic              if_in_ds,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [ADDR_W-1:0] id_cur_instaddress,
  output logic [ADDR_W-1:0] id_next_instaddress,
  output logic              id_excp,
  output logic              id_in_ds,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t state;

  logic [INST_W-1:0] head_inst;
  logic [ADDR_W-1:0] head_cur;
  logic [ADDR_W-1:0] head_next;
  logic              head_excp;
  logic              head_in_ds;

`ifdef IF_ID_SKID_EN
  logic [INST_W-1:0] skid_inst;
  logic [ADDR_W-1:0] skid_cur;
  logic [ADDR_W-1:0] skid_next;
  logic              skid_excp;
  logic              skid_in_ds;
`endif

  logic push;
  logic pop;

  assign id_valid = (state != EMPTY);
  assign push     = if_valid && if_ready;
  assign pop      = id_valid && id_ready;

`ifdef IF_ID_SKID_EN
  assign if_ready = rst && (state != TWO);
`else
  assign if_ready = rst && (!id_valid || id_ready);
`endif

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      state      <= EMPTY;
      head_inst  <= '0;
      head_cur   <= '0;
      head_next  <= '0;
      head_excp  <= 1'b0;
      head_in_ds <= 1'b0;
`ifdef IF_ID_SKID_EN
      skid_inst  <= '0;
      skid_cur   <= '0;
      skid_next  <= '0;
      skid_excp  <= 1'b0;
      skid_in_ds <= 1'b0;
`endif
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            state      <= ONE;
            head_inst  <= if_inst;
            head_cur   <= if_cur_instaddress;
            head_next  <= if_next_instaddress;
            head_excp  <= if_excp;
            head_in_ds <= if_in_ds;
          end
        end
        ONE: begin
          if (push && pop) begin
            head_inst  <= if_inst;
            head_cur   <= if_cur_instaddress;
            head_next  <= if_next_instaddress;
            head_excp  <= if_excp;
            head_in_ds <= if_in_ds;
`ifdef IF_ID_SKID_EN
          end else if (push) begin
            state      <= TWO;
            skid_inst  <= if_inst;
            skid_cur   <= if_cur_instaddress;
            skid_next  <= if_next_instaddress;
            skid_excp  <= if_excp;
            skid_in_ds <= if_in_ds;
`endif
          end else if (pop) begin
            // Clearing the head on the way to EMPTY is what makes the bubble read as zero.
            state      <= EMPTY;
            head_inst  <= '0;
            head_cur   <= '0;
            head_next  <= '0;
            head_excp  <= 1'b0;
            head_in_ds <= 1'b0;
          end
        end
`ifdef IF_ID_SKID_EN
        TWO: begin
          if (pop) begin
            state      <= ONE;
            head_inst  <= skid_inst;
            head_cur   <= skid_cur;
            head_next  <= skid_next;
            head_excp  <= skid_excp;
            head_in_ds <= skid_in_ds;
            skid_inst  <= '0;
            skid_cur   <= '0;
            skid_next  <= '0;
            skid_excp  <= 1'b0;
            skid_in_ds <= 1'b0;
          end
        end
`endif
        default: begin
          state      <= EMPTY;
          head_inst  <= '0;
          head_cur   <= '0;
          head_next  <= '0;
          head_excp  <= 1'b0;
          head_in_ds <= 1'b0;
        end
      endcase
    end
  end

  assign id_inst             = head_inst;
  assign id_cur_instaddress  = head_cur;
  assign id_next_instaddress = head_next;
  assign id_excp             = head_excp;
  assign id_in_ds            = head_in_ds;
  assign occupancy           = state;

endmodule
